// File: rtl/color_pkg.sv
// Shared types for the color loader: FSM states, sel codes,
// default saturation ceiling and a state-to-sel helper.
package color_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_R,
    ST_LOAD_G,
    ST_LOAD_B,
    ST_READY,
    ST_RUN
  } state_t;

  localparam logic [1:0] SEL_R    = 2'b00;
  localparam logic [1:0] SEL_G    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam int MAX_VALUE_DEF = 15;

  function automatic logic [1:0] sel_of(state_t s);
    logic [1:0] v;
    v = SEL_NONE;
    case (s)
      ST_LOAD_R: v = SEL_R;
      ST_LOAD_G: v = SEL_G;
      ST_LOAD_B: v = SEL_B;
      default:   v = SEL_NONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter,
// one-cycle pulse on each accepted 0->1 level change.
// Ports: clk, rst (async high), btn (raw), press (pulse out).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;

  // r_last tracks the synchronized level; a change restarts
  // the count, and the accepted level moves only once the
  // count has saturated on an unchanged sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn};
      r_press <= 1'b0;
      if (r_sync[1] != r_last) begin
        r_last <= r_sync[1];
        r_cnt  <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_level != r_last) begin
        r_level <= r_last;
        r_press <= r_last;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/color_loader.sv
// Operator entry: debounced load/start, clamped R/G/B capture,
// enter pulse and RUN freeze until dispense_done.
// Ports: clk, rst, sw, btn_load, btn_start, dispense_done in;
// R, G, B, enter, sel, ready, busy out (all registered).
module color_loader
  import color_pkg::*;
#(
  parameter int WIDTH           = 5,
  parameter int MAX_VALUE       = MAX_VALUE_DEF,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_start,
  input  logic             dispense_done,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] B,
  output logic             enter,
  output logic [1:0]       sel,
  output logic             ready,
  output logic             busy
);

  localparam logic [WIDTH-1:0] W_MAX = WIDTH'(MAX_VALUE);

  logic             w_load;
  logic             w_start;
  logic [WIDTH-1:0] r_sw_s1;
  logic [WIDTH-1:0] r_sw_s2;
  logic [WIDTH-1:0] w_clamped;

  state_t           r_state;
  state_t           w_next;
  logic             w_enter;
  logic             w_wr_r;
  logic             w_wr_g;
  logic             w_wr_b;

  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_b;
  logic             r_enter;
  logic [1:0]       r_sel;
  logic             r_ready;
  logic             r_busy;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_load (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_load),
    .press(w_load)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_start (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_start),
    .press(w_start)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  assign w_clamped = (r_sw_s2 > W_MAX) ? W_MAX : r_sw_s2;

  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    w_wr_r  = 1'b0;
    w_wr_g  = 1'b0;
    w_wr_b  = 1'b0;
    unique case (r_state)
      ST_LOAD_R: begin
        if (w_load) begin
          w_wr_r = 1'b1;
          w_next = ST_LOAD_G;
        end
      end
      ST_LOAD_G: begin
        if (w_load) begin
          w_wr_g = 1'b1;
          w_next = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (w_load) begin
          w_wr_b = 1'b1;
          w_next = ST_READY;
        end
      end
      ST_READY: begin
        // start outranks a coincident load
        if (w_start) begin
          w_enter = 1'b1;
          w_next  = ST_RUN;
        end else if (w_load) begin
          w_next = ST_LOAD_R;
        end
      end
      ST_RUN: begin
        if (dispense_done) w_next = ST_READY;
      end
      default: w_next = ST_LOAD_R;
    endcase
  end

  // Status outputs are registered from the next state so
  // enter and busy rise on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD_R;
      r_enter <= 1'b0;
      r_sel   <= SEL_R;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_next;
      r_enter <= w_enter;
      r_sel   <= sel_of(w_next);
      r_ready <= (w_next == ST_READY);
      r_busy  <= (w_next == ST_RUN);
      if (w_wr_r) r_r <= w_clamped;
      if (w_wr_g) r_g <= w_clamped;
      if (w_wr_b) r_b <= w_clamped;
    end
  end

  assign R     = r_r;
  assign G     = r_g;
  assign B     = r_b;
  assign enter = r_enter;
  assign sel   = r_sel;
  assign ready = r_ready;
  assign busy  = r_busy;

endmodule

// File: tb/tb_color_loader.sv
// Self-checking bench for color_loader: directed steps plus
// randomized operations against an abstract recipe model.
module tb_color_loader;

  logic       clk;
  logic       rst;
  logic [4:0] sw;
  logic       btn_load;
  logic       btn_start;
  logic       dispense_done;
  logic [4:0] R;
  logic [4:0] G;
  logic [4:0] B;
  logic       enter;
  logic [1:0] sel;
  logic       ready;
  logic       busy;

  color_loader #(
    .WIDTH(5),
    .MAX_VALUE(15),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn_load     (btn_load),
    .btn_start    (btn_start),
    .dispense_done(dispense_done),
    .R            (R),
    .G            (G),
    .B            (B),
    .enter        (enter),
    .sel          (sel),
    .ready        (ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // enter monitor, sampled mid-cycle
  int n_enter_mon = 0;
  int n_enter_bad = 0;
  always @(negedge clk) begin
    if (enter) n_enter_mon = n_enter_mon + 1;
    if (enter && !busy) n_enter_bad = n_enter_bad + 1;
  end

  // Model: phase 0..2 = awaiting R/G/B, 3 = ready, 4 = running
  int ph;
  int exp_v[3];
  int e0;

  function automatic int clampv(int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag, int exp_enter);
    chk({tag, ".R"}, 32'(R), 32'(exp_v[0]));
    chk({tag, ".G"}, 32'(G), 32'(exp_v[1]));
    chk({tag, ".B"}, 32'(B), 32'(exp_v[2]));
    chk({tag, ".sel"}, 32'(sel),
        32'((ph < 3) ? ph : 3));
    chk({tag, ".ready"}, 32'(ready), 32'(ph == 3));
    chk({tag, ".busy"}, 32'(busy), 32'(ph == 4));
    chk({tag, ".enter_n"}, 32'(n_enter_mon - e0),
        32'(exp_enter));
  endtask

  task automatic press(logic l, logic s);
    btn_load  = l;
    btn_start = s;
    step(12);
    btn_load  = 1'b0;
    btn_start = 1'b0;
    step(12);
  endtask

  // one operation: kind 0=load 1=start 2=both 3=done
  task automatic op(string tag, int kind, int v);
    int ex;
    ex = 0;
    e0 = n_enter_mon;
    sw = 5'(v);
    step(4);
    case (kind)
      0: press(1'b1, 1'b0);
      1: press(1'b0, 1'b1);
      2: press(1'b1, 1'b1);
      default: begin
        dispense_done = 1'b1;
        step(1);
        dispense_done = 1'b0;
        step(2);
      end
    endcase
    if (kind == 3) begin
      if (ph == 4) ph = 3;
    end else if (ph == 3 && kind != 0) begin
      ph = 4;
      ex = 1;
    end else if (ph == 3) begin
      ph = 0;
    end else if (ph < 3 && kind != 1) begin
      exp_v[ph] = clampv(v);
      ph++;
    end
    check_all(tag, ex);
  endtask

  initial begin
    rst = 1'b1;
    sw = '0;
    btn_load = 1'b0;
    btn_start = 1'b0;
    dispense_done = 1'b0;
    ph = 0;
    exp_v[0] = 0;
    exp_v[1] = 0;
    exp_v[2] = 0;
    e0 = 0;
    step(3);
    rst = 1'b0;
    step(2);
    e0 = n_enter_mon;
    check_all("reset", 0);

    // directed recipe load and dispense
    op("ldR3", 0, 3);
    op("ldG7", 0, 7);
    op("ldB12", 0, 12);
    op("start", 1, 0);
    op("run_ld9", 0, 9);
    op("run_st", 1, 0);
    op("done", 3, 0);
    op("redo", 1, 0);
    op("done2", 3, 0);

    // saturation boundaries
    op("rdy_ld", 0, 0);
    op("clamp20", 0, 20);
    op("clamp15", 0, 15);
    op("clamp0", 0, 0);
    op("both", 2, 9);
    op("done3", 3, 0);
    op("rdy_ld2", 0, 0);
    op("idle_done", 3, 0);
    op("ld_start", 1, 0);

    // bounce then stable: one capture, exact latency
    e0 = n_enter_mon;
    sw = 5'd5;
    step(4);
    for (int i = 0; i < 10; i++) begin
      btn_load = ~btn_load;
      step(2);
    end
    check_all("bounce", 0);
    btn_load = 1'b1;
    step(7);
    chk("lat_e6.sel", 32'(sel), 32'd0);
    step(1);
    chk("lat_e7.sel", 32'(sel), 32'd1);
    chk("lat_e7.R", 32'(R), 32'd5);
    btn_load = 1'b0;
    step(12);
    exp_v[0] = 5;
    ph = 1;
    check_all("bounce_rel", 0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      op("rnd", int'($urandom_range(0, 3)),
         int'($urandom_range(0, 31)));
    end

    // reach RUN, then asynchronous reset mid-run
    for (int i = 0; i < 8 && ph != 3; i++) begin
      if (ph == 4) op("pre_d", 3, 0);
      else op("pre_l", 0, int'($urandom_range(0, 31)));
    end
    op("pre_st", 1, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    ph = 0;
    exp_v[0] = 0;
    exp_v[1] = 0;
    exp_v[2] = 0;
    e0 = n_enter_mon;
    check_all("async_rst", 0);
    step(2);
    rst = 1'b0;
    step(1);
    op("post_st", 1, 0);
    op("post_ld", 0, 21);
    chk("enter_wo_busy", 32'(n_enter_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/color_loader.md
# color_loader

Operator-entry stage placed directly upstream of the RGB dispense timer. It debounces two push-buttons, loads three 5-bit motor durations (R, G, B) in sequence from the switch bank, and clamps each to what the timer's 4-bit counter can reach. It then issues the single-cycle `enter` pulse that starts a dispense and freezes R/G/B until the cycle is reported done.

## Interface
- `WIDTH`, 5: width of switch input and of each R/G/B output.
- `MAX_VALUE`, 15: saturation ceiling for stored values (timer counter limit).
- `DEBOUNCE_CYCLES`, 4: consecutive stable samples required to accept a button level.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sw`  in  WIDTH  raw switch value, asynchronous to `clk`.
- `btn_load`  in  1  raw "store value" button, asynchronous, bouncing.
- `btn_start`  in  1  raw "dispense" button, asynchronous, bouncing.
- `dispense_done`  in  1  one-cycle pulse from integration logic when the B phase ends.
- `R`, `G`, `B`  out  WIDTH  stored durations, registered, fed straight to the timer.
- `enter`  out  1  one-cycle start pulse to the timer.
- `sel`  out  2  channel currently awaiting a value: 00=R, 01=G, 10=B, 11=none.
- `ready`  out  1  all three values loaded, start accepted.
- `busy`  out  1  dispense in progress, R/G/B frozen.

## Operation
- Each button: 2-FF synchronizer, then debouncer. Any change of the synchronized level clears the stability counter. Accepted level updates after `DEBOUNCE_CYCLES` equal samples. Accepted 0→1 transition yields exactly one press pulse. Release is debounced too, so one press gives one pulse.
- `sw` is sampled through a 2-FF synchronizer. Stored value is `min(sw_sync, MAX_VALUE)`, so WIDTH=5 input 16..31 stores 15.
- FSM states: LOAD_R, LOAD_G, LOAD_B, READY, RUN.
  - LOAD_R / LOAD_G / LOAD_B: a load press writes the clamped value to that channel, then advances R→G→B→READY. Start presses are ignored.
  - READY: a start press asserts `enter` for one cycle, then goes to RUN. A load press returns to LOAD_R; old values persist until overwritten. If load and start presses arrive in the same cycle, start wins.
  - RUN: load and start presses are discarded; R/G/B are held constant. `dispense_done` goes to READY, so the same recipe can be re-dispensed.
- `dispense_done` outside RUN is ignored.
- Outputs are all registered. `sel` = 00/01/10 in LOAD_R/G/B and 11 otherwise. `ready` = state is READY. `busy` = state is RUN.

## Timing
- Reset values: R=G=B=0, `enter`=0, `sel`=00, `ready`=0, `busy`=0, state LOAD_R, debouncers at accepted level 0 with counters cleared.
- Reset is asynchronous. Asserting it mid-RUN or mid-load returns to LOAD_R immediately; `enter` can never be high during or on the first edge after reset.
- Button latency: the first edge that samples a stable high at the synchronizer input is edge 0. The press pulse is high in the cycle after edge 2+`DEBOUNCE_CYCLES`. The channel register, state and `sel` update on the following edge.
- Start press in READY: `enter` and `busy` rise on the same edge. `enter` is high for exactly one cycle. R/G/B are already stable at least one cycle before `enter`.
- `dispense_done` sampled in RUN: `busy` falls and `ready` rises on the next edge.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no pulse and no state change.

## Structure
- Shared package `color_pkg`:
  - state enum (LOAD_R, LOAD_G, LOAD_B, READY, RUN);
  - `sel` channel codes;
  - `MAX_VALUE` default.
- Sub-module `btn_debounce` (synchronizer, stability counter, rising-edge pulse). Instantiated twice, parameterized by `DEBOUNCE_CYCLES`.
- Top holds the `sw` synchronizer, clamp, FSM and R/G/B registers.

## Test plan
- Reset, then three clean load presses with sw=3, 7, 12 → R=3, G=7, B=12; `sel` steps 00→01→10→11; `ready`=1 after third capture.
- READY, clean start press → `enter` high exactly one cycle, `busy`=1; a load press with sw=9 during RUN leaves R/G/B unchanged; `dispense_done` → `ready`=1, `busy`=0.
- sw=20 on the R load → R=15; sw=15 → 15; sw=0 → 0.
- `btn_load` toggling every 2 cycles for 20 cycles, then held high (DEBOUNCE_CYCLES=4) → exactly one capture, pulse at edge 6 after stable sampling.
- In READY, load and start press pulses coincide → `enter` asserted, state RUN, R/G/B unchanged.
- `rst` asserted asynchronously mid-RUN → all outputs return to reset values before the next clock edge; no `enter` afterwards until a full reload and start.
